// File: rtl/result_collector_pkg.sv
// Shared definitions for the result collector and the control unit that feeds it.
// Holds the FSM encoding and the default sizing parameters.
package result_collector_pkg;

  localparam int DEFAULT_P               = 4;
  localparam int DEFAULT_INDEX_WIDTH     = 8;
  localparam int DEFAULT_MEMORY_SIZE_LOG = 10;

  typedef enum logic [2:0] {
    IDLE,
    ARBITRATE,
    WRITE,
    ACK,
    FINISH
  } state_t;

endpackage

// File: rtl/result_collector_rr_arbiter.sv
// Combinational round-robin arbiter. It picks the first request at or after the
// pointer and wraps modulo p.
module rr_arbiter #(
  parameter int p         = 4,
  parameter int ptr_width = (p > 1) ? $clog2(p) : 1
) (
  input  logic [p-1:0]         i_Request,
  input  logic [ptr_width-1:0] i_Pointer,
  output logic [ptr_width-1:0] o_Grant_Index,
  output logic                 o_Grant_Valid
);

  logic                 found;
  logic [ptr_width-1:0] cand;

  // NOTE: every output and temporary gets a default first, so no path through
  // this block can infer a latch.
  always_comb begin
    found         = 1'b0;
    cand          = '0;
    o_Grant_Index = '0;
    for (int i = 0; i < p; i++) begin
      cand = ptr_width'((int'(i_Pointer) + i) % p);
      if (!found && i_Request[cand]) begin
        found         = 1'b1;
        o_Grant_Index = cand;
      end
    end
    o_Grant_Valid = found;
  end

endmodule

// File: rtl/result_collector.sv
// Gathers finished result blocks from the processors assigned in a round and writes
// them row-major into matrix C. Each processor is acked, then Result Ready pulses once.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int p               = DEFAULT_P,
  parameter int index_width     = DEFAULT_INDEX_WIDTH,
  parameter int block_size      = 2,
  parameter int data_width      = 32,
  parameter int memory_size_log = DEFAULT_MEMORY_SIZE_LOG
) (
  input  logic                                  i_Clock,
  input  logic                                  i_Reset,
  input  logic                                  i_Round_Start,
  input  logic [p-1:0]                          i_Active_Mask,
  input  logic [index_width-1:0]                i_Gamma,
  input  logic [memory_size_log-1:0]            i_C_Base_Address,
  input  logic [p-1:0]                          i_Proc_Done,
  input  logic [p*index_width-1:0]              i_Proc_Row,
  input  logic [p*index_width-1:0]              i_Proc_Col,
  input  logic [p*data_width-1:0]               i_Proc_Word,
  output logic [$clog2(block_size*block_size)-1:0] o_Elem_Index,
  output logic [p-1:0]                          o_Proc_Ack,
  output logic                                  o_Mem_Write_Enable,
  output logic [memory_size_log-1:0]            o_Mem_Addr,
  output logic [data_width-1:0]                 o_Mem_Data,
  output logic                                  o_Result_Ready,
  output logic                                  o_Busy,
  output logic                                  o_Overlap_Error
);

  localparam int elems     = block_size * block_size;
  localparam int cnt_width = $clog2(elems);
  localparam int ptr_width = (p > 1) ? $clog2(p) : 1;
  localparam int aw        = memory_size_log;

  state_t                 r_State, w_Next_State;
  logic [p-1:0]           r_Pending;
  logic [ptr_width-1:0]   r_Pointer, r_Grant;
  logic [index_width-1:0] r_Row, r_Col;
  logic [cnt_width-1:0]   r_Cnt;
  logic                   r_Overlap_Error;

  logic [ptr_width-1:0]   w_Arb_Index;
  logic                   w_Arb_Valid;
  logic [p-1:0]           w_Grant_Mask;
  logic                   w_Last_Elem;
  logic [aw-1:0]          w_Elem_Row, w_Elem_Col, w_Addr;

  rr_arbiter #(.p(p), .ptr_width(ptr_width)) u_arbiter (
    .i_Request     (r_Pending & i_Proc_Done),
    .i_Pointer     (r_Pointer),
    .o_Grant_Index (w_Arb_Index),
    .o_Grant_Valid (w_Arb_Valid)
  );

  assign w_Grant_Mask = p'(1) << r_Grant;
  assign w_Last_Elem  = (r_Cnt == cnt_width'(elems - 1));

  // Working modulo 2^aw throughout gives the same bits as full precision then truncation.
  assign w_Elem_Row = aw'(int'(r_Cnt) / block_size);
  assign w_Elem_Col = aw'(int'(r_Cnt) % block_size);
  assign w_Addr     = i_C_Base_Address
                    + (aw'(r_Row) * aw'(block_size) + w_Elem_Row) * (aw'(i_Gamma) * aw'(block_size))
                    + aw'(r_Col) * aw'(block_size) + w_Elem_Col;

  // NOTE: non-blocking assignments for all registered state, so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State         <= IDLE;
      r_Pending       <= '0;
      r_Pointer       <= '0;
      r_Grant         <= '0;
      r_Row           <= '0;
      r_Col           <= '0;
      r_Cnt           <= '0;
      r_Overlap_Error <= 1'b0;
    end else begin
      r_State <= w_Next_State;
      if (i_Round_Start && r_State != IDLE) r_Overlap_Error <= 1'b1;
      case (r_State)
        IDLE:      if (i_Round_Start) r_Pending <= i_Active_Mask;
        ARBITRATE: if (w_Arb_Valid) begin
          r_Grant <= w_Arb_Index;
          r_Row   <= i_Proc_Row[int'(w_Arb_Index)*index_width +: index_width];
          r_Col   <= i_Proc_Col[int'(w_Arb_Index)*index_width +: index_width];
          r_Cnt   <= '0;
        end
        WRITE:     r_Cnt <= r_Cnt + cnt_width'(1);
        ACK: begin
          r_Pending <= r_Pending & ~w_Grant_Mask;
          r_Pointer <= (r_Grant == ptr_width'(p - 1)) ? '0 : r_Grant + ptr_width'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_Next_State       = r_State;
    o_Elem_Index       = '0;
    o_Proc_Ack         = '0;
    o_Mem_Write_Enable = 1'b0;
    o_Mem_Addr         = '0;
    o_Mem_Data         = '0;
    o_Result_Ready     = 1'b0;
    case (r_State)
      IDLE:      if (i_Round_Start) w_Next_State = (i_Active_Mask == '0) ? FINISH : ARBITRATE;
      ARBITRATE: if (w_Arb_Valid) w_Next_State = WRITE;
      WRITE: begin
        o_Elem_Index       = r_Cnt;
        o_Mem_Write_Enable = 1'b1;
        o_Mem_Addr         = w_Addr;
        o_Mem_Data         = i_Proc_Word[int'(r_Grant)*data_width +: data_width];
        if (w_Last_Elem) w_Next_State = ACK;
      end
      ACK: begin
        o_Proc_Ack   = w_Grant_Mask;
        w_Next_State = ((r_Pending & ~w_Grant_Mask) == '0) ? FINISH : ARBITRATE;
      end
      FINISH: begin
        o_Result_Ready = 1'b1;
        w_Next_State   = IDLE;
      end
      default: w_Next_State = IDLE;
    endcase
  end

  assign o_Busy          = (r_State != IDLE);
  assign o_Overlap_Error = r_Overlap_Error;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: expected writes and acks are queued when a
// round is launched and popped by a monitor as the DUT produces them.
module tb_result_collector;

  localparam int P   = 4;
  localparam int IW  = 8;
  localparam int BS  = 2;
  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int AWW = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, round_start;
  logic [P-1:0]  active_mask, done_req, done_acked, proc_done;
  logic [IW-1:0] gamma;
  logic [AW-1:0] base;
  logic [AWW-1:0] base_w;
  logic [P*IW-1:0] proc_row, proc_col;
  logic [P*DW-1:0] proc_word, proc_word_w;
  logic [7:0]    round_tag;
  bit            wrap_en;

  logic [1:0]    elem_index, w_elem_index;
  logic [P-1:0]  proc_ack, w_proc_ack;
  logic          mem_we, w_mem_we;
  logic [AW-1:0] mem_addr;
  logic [AWW-1:0] w_mem_addr;
  logic [DW-1:0] mem_data, w_mem_data;
  logic          result_ready, busy, overlap_error;
  logic          w_result_ready, w_busy, w_overlap_error;
  logic [51:0]   all_out;

  wr_t exp_w[$];
  wr_t exp_ww[$];
  logic [P-1:0] exp_ack[$];
  wr_t mon_e;
  logic [P-1:0] mon_a;
  int n_checks = 0;
  int n_errors = 0;
  int rr_count = 0;
  int rr0, n;

  assign proc_done = done_req & ~done_acked;
  assign all_out   = {elem_index, proc_ack, mem_we, mem_addr, mem_data, result_ready, busy, overlap_error};

  function automatic logic [DW-1:0] word_of(int k, int idx, logic [7:0] t);
    return {8'(k), t, 8'h5A, 8'(idx)};
  endfunction

  function automatic int addr_of(int b, int row, int col, int g, int idx);
    return b + (row * BS + idx / BS) * (g * BS) + col * BS + idx % BS;
  endfunction

  always_comb begin
    proc_word = '0;
    for (int k = 0; k < P; k++) proc_word[k*DW +: DW] = word_of(k, int'(elem_index), round_tag);
  end

  always_comb begin
    proc_word_w = '0;
    for (int k = 0; k < P; k++) proc_word_w[k*DW +: DW] = word_of(k, int'(w_elem_index), round_tag);
  end

  result_collector #(.p(P), .index_width(IW), .block_size(BS), .data_width(DW),
                     .memory_size_log(AW)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Round_Start(round_start), .i_Active_Mask(active_mask),
    .i_Gamma(gamma), .i_C_Base_Address(base), .i_Proc_Done(proc_done),
    .i_Proc_Row(proc_row), .i_Proc_Col(proc_col), .i_Proc_Word(proc_word),
    .o_Elem_Index(elem_index), .o_Proc_Ack(proc_ack), .o_Mem_Write_Enable(mem_we),
    .o_Mem_Addr(mem_addr), .o_Mem_Data(mem_data), .o_Result_Ready(result_ready),
    .o_Busy(busy), .o_Overlap_Error(overlap_error)
  );

  result_collector #(.p(P), .index_width(IW), .block_size(BS), .data_width(DW),
                     .memory_size_log(AWW)) dut_w (
    .i_Clock(clk), .i_Reset(rst), .i_Round_Start(round_start), .i_Active_Mask(active_mask),
    .i_Gamma(gamma), .i_C_Base_Address(base_w), .i_Proc_Done(proc_done),
    .i_Proc_Row(proc_row), .i_Proc_Col(proc_col), .i_Proc_Word(proc_word_w),
    .o_Elem_Index(w_elem_index), .o_Proc_Ack(w_proc_ack), .o_Mem_Write_Enable(w_mem_we),
    .o_Mem_Addr(w_mem_addr), .o_Mem_Data(w_mem_data), .o_Result_Ready(w_result_ready),
    .o_Busy(w_busy), .o_Overlap_Error(w_overlap_error)
  );

  task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_proc(int k, int row, int col);
    proc_row[k*IW +: IW] = IW'(row);
    proc_col[k*IW +: IW] = IW'(col);
  endtask

  task automatic push_block(int k, int count, bit with_ack);
    wr_t e;
    for (int i = 0; i < count; i++) begin
      e.addr = AW'(addr_of(int'(base), int'(proc_row[k*IW +: IW]), int'(proc_col[k*IW +: IW]),
                           int'(gamma), i));
      e.data = word_of(k, i, round_tag);
      exp_w.push_back(e);
    end
    if (with_ack) exp_ack.push_back(P'(1) << k);
  endtask

  task automatic start_round(logic [P-1:0] mask);
    active_mask = mask;
    round_start = 1'b1;
    step();
    round_start = 1'b0;
  endtask

  task automatic wait_ack(output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      cycles++;
      seen = (proc_ack != '0);
    end
    if (!seen) check("ack timeout", 64'(0), 64'(1));
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_w.size() == 0) check("spurious write", 64'(mem_addr), 64'h3ff_ffff);
      else begin
        mon_e = exp_w.pop_front();
        check("write addr", 64'(mem_addr), 64'(mon_e.addr));
        check("write data", 64'(mem_data), 64'(mon_e.data));
      end
    end
    if (proc_ack != '0) begin
      if (exp_ack.size() == 0) check("spurious ack", 64'(proc_ack), 64'(0));
      else begin
        mon_a = exp_ack.pop_front();
        check("ack order", 64'(proc_ack), 64'(mon_a));
      end
    end
    if (wrap_en && w_mem_we) begin
      if (exp_ww.size() == 0) check("wrap spurious write", 64'(w_mem_addr), 64'hff);
      else begin
        mon_e = exp_ww.pop_front();
        check("wrap addr", 64'(w_mem_addr), 64'(mon_e.addr));
        check("wrap data", 64'(w_mem_data), 64'(mon_e.data));
      end
    end
    if (result_ready) rr_count++;
    if (rst || round_start) done_acked = '0;
    else done_acked = done_acked | proc_ack;
  end

  initial begin
    rst = 1'b1; round_start = 1'b0; active_mask = '0; gamma = 8'd2; base = 10'd100;
    base_w = '0; done_req = '0; proc_row = '0; proc_col = '0; round_tag = 8'h00; wrap_en = 1'b0;
    step(); step();
    check("outputs in reset", 64'(all_out), 64'(0));
    rst = 1'b0;
    step();
    check("outputs idle after reset", 64'(all_out), 64'(0));

    // Base case: processor 0, row 1, col 0, gamma 2, base 100.
    set_proc(0, 1, 0); round_tag = 8'h11; done_req = 4'b0001;
    push_block(0, 4, 1'b1);
    start_round(4'b0001);
    check("busy in round", 64'(busy), 64'(1));
    wait_ack(n);
    check("base ack latency", 64'(n), 64'(5));
    check("base ack vector", 64'(proc_ack), 64'(4'b0001));
    check("no ready with ack", 64'(result_ready), 64'(0));
    step();
    check("base ready", 64'(result_ready), 64'(1));
    check("ack one cycle", 64'(proc_ack), 64'(0));
    step();
    check("ready one cycle", 64'(result_ready), 64'(0));
    check("idle after base", 64'(busy), 64'(0));
    check("base writes drained", 64'(exp_w.size()), 64'(0));
    done_req = '0;

    // Empty mask goes straight to FINISH.
    rr0 = rr_count;
    start_round(4'b0000);
    check("empty ready", 64'(result_ready), 64'(1));
    step();
    check("empty ready pulse", 64'(result_ready), 64'(0));
    check("empty idle", 64'(busy), 64'(0));
    check("empty ready count", 64'(rr_count - rr0), 64'(1));

    // Round-robin: 3 and 1 done first, pointer sits at 1; 0 and 2 join during 3's write.
    gamma = 8'd4; round_tag = 8'h22;
    for (int k = 0; k < P; k++) set_proc(k, k, 3 - k);
    push_block(1, 4, 1'b1); push_block(3, 4, 1'b1); push_block(0, 4, 1'b1); push_block(2, 4, 1'b1);
    done_req = 4'b1010; rr0 = rr_count;
    start_round(4'b1111);
    for (int i = 0; i < 4; i++) begin
      wait_ack(n);
      check("rr no early ready", 64'(rr_count - rr0), 64'(0));
      if (i == 0) begin
        step(); step();
        done_req = 4'b1111;
      end
    end
    step();
    check("rr ready", 64'(result_ready), 64'(1));
    step();
    check("rr single ready", 64'(rr_count - rr0), 64'(1));
    check("rr idle", 64'(busy), 64'(0));
    check("rr acks drained", 64'(exp_ack.size()), 64'(0));
    done_req = '0;

    // A done processor outside the mask is ignored.
    gamma = 8'd2; round_tag = 8'h33;
    set_proc(0, 1, 1); set_proc(1, 0, 0);
    push_block(0, 4, 1'b1);
    done_req = 4'b0011;
    start_round(4'b0001);
    wait_ack(n);
    step();
    check("mask ready", 64'(result_ready), 64'(1));
    step(); step();
    check("mask idle", 64'(busy), 64'(0));
    check("mask writes drained", 64'(exp_w.size()), 64'(0));
    done_req = '0;

    // Address wrap on a 4-bit memory: 14, 15, 0, 1.
    gamma = 8'd1; round_tag = 8'h44; base_w = 4'd14;
    set_proc(0, 0, 0);
    push_block(0, 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      mon_e.addr = AW'(addr_of(14, 0, 0, 1, i) % 16);
      mon_e.data = word_of(0, i, round_tag);
      exp_ww.push_back(mon_e);
    end
    wrap_en = 1'b1; done_req = 4'b0001;
    start_round(4'b0001);
    wait_ack(n);
    step(); step();
    wrap_en = 1'b0;
    check("wrap writes drained", 64'(exp_ww.size()), 64'(0));
    done_req = '0;

    // Overlapping start during WRITE.
    gamma = 8'd2; round_tag = 8'h55;
    set_proc(0, 1, 0);
    push_block(0, 4, 1'b1);
    done_req = 4'b0001;
    start_round(4'b0001);
    check("no overlap yet", 64'(overlap_error), 64'(0));
    step(); step();
    active_mask = 4'b1111; round_start = 1'b1;
    step();
    round_start = 1'b0;
    check("overlap set", 64'(overlap_error), 64'(1));
    wait_ack(n);
    check("overlap ack latency", 64'(n), 64'(2));
    step();
    check("overlap ready", 64'(result_ready), 64'(1));
    step();
    check("overlap idle", 64'(busy), 64'(0));
    check("overlap sticky", 64'(overlap_error), 64'(1));
    done_req = '0;

    // Reset two words into a block: no ack, no ready, outputs cleared.
    round_tag = 8'h66; set_proc(0, 2, 0);
    push_block(0, 2, 1'b0);
    done_req = 4'b0001; rr0 = rr_count;
    start_round(4'b0001);
    step(); step();
    rst = 1'b1;
    step();
    check("reset mid-write outputs", 64'(all_out), 64'(0));
    step(); step();
    rst = 1'b0;
    step(); step();
    check("after reset outputs", 64'(all_out), 64'(0));
    check("reset no ready", 64'(rr_count - rr0), 64'(0));
    check("reset pre-writes drained", 64'(exp_w.size()), 64'(0));
    done_req = '0;

    // Fresh round after reset: pointer back at 0, so 0 before 1.
    round_tag = 8'h77; set_proc(0, 0, 0); set_proc(1, 0, 1);
    push_block(0, 4, 1'b1); push_block(1, 4, 1'b1);
    done_req = 4'b0011; rr0 = rr_count;
    start_round(4'b0011);
    wait_ack(n);
    wait_ack(n);
    step();
    check("post-reset ready", 64'(result_ready), 64'(1));
    step();
    check("post-reset ready count", 64'(rr_count - rr0), 64'(1));
    done_req = '0;
    step();
    check("final writes drained", 64'(exp_w.size()), 64'(0));
    check("final acks drained", 64'(exp_ack.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
